// File: rtl/elastic_pipeline.sv
// Elastic pipeline: STAGES cascaded skid-buffer slices carrying a valid/ready stream.
// Latency: STAGES cycles from acceptance to Out_valid when never stalled; 1 word/cycle sustained.
// Backpressure: In_ready = !skid_valid of slice 0 (registered), no comb path from Out_ready; capacity 2*STAGES.
// Optional feature macro: ELASTIC_PIPELINE_OCCUPANCY_EN adds the registered Occupancy output.
module elastic_pipeline #(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WORD_LENGTH-1:0] In_data,
  input  logic                   In_valid,
  output logic                   In_ready,
  output logic [WORD_LENGTH-1:0] Out_data,
  output logic                   Out_valid,
  input  logic                   Out_ready
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] Occupancy
`endif
);

  if (WORD_LENGTH <= 0) begin : g_bad_width
    $error("elastic_pipeline: WORD_LENGTH must be > 0");
  end
  if (STAGES <= 0) begin : g_bad_stages
    $error("elastic_pipeline: STAGES must be > 0");
  end

  // Per-slice state flattened so neighbouring slices can see each other.
  logic [STAGES-1:0]      main_valid;
  logic [STAGES-1:0]      skid_valid;
  logic [STAGES-1:0]      up_valid;
  logic [WORD_LENGTH-1:0] main_data [STAGES];
  logic [WORD_LENGTH-1:0] up_data   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic                   m_valid;
    logic                   s_valid;
    logic [WORD_LENGTH-1:0] m_data;
    logic [WORD_LENGTH-1:0] s_data;
    logic                   dn_ready;
    logic                   in_fire;

    // Upstream of slice 0 is the block input; otherwise the previous slice's main register.
    if (k == 0) begin : g_first
      assign up_valid[k] = In_valid;
      assign up_data[k]  = In_data;
    end else begin : g_chain
      assign up_valid[k] = main_valid[k-1];
      assign up_data[k]  = main_data[k-1];
    end

    // Downstream ready is the consumer for the last slice, else the next slice's registered ready.
    if (k == STAGES-1) begin : g_last
      assign dn_ready = Out_ready;
    end else begin : g_mid
      assign dn_ready = ~skid_valid[k+1];
    end

    // Our own upstream ready is simply "skid empty", a register output.
    assign in_fire = up_valid[k] & ~s_valid;

    // Main register advances when empty or drained; otherwise an incoming word parks in the skid.
    always_ff @(posedge Clock) begin
      if (!Reset) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
        m_data  <= '0;
        s_data  <= '0;
      end else if (!m_valid || dn_ready) begin
        // Data only reloads when a real word arrives, so an empty slice keeps its last value.
        if (s_valid) begin
          m_data <= s_data;
        end else if (in_fire) begin
          m_data <= up_data[k];
        end
        m_valid <= s_valid | in_fire;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        s_data  <= up_data[k];
        s_valid <= 1'b1;
      end
    end

    assign main_valid[k] = m_valid;
    assign skid_valid[k] = s_valid;
    assign main_data[k]  = m_data;
  end

  assign In_ready  = ~skid_valid[0];
  assign Out_valid = main_valid[STAGES-1];
  assign Out_data  = main_data[STAGES-1];

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(2*STAGES+1);

  logic             occ_in_fire;
  logic             occ_out_fire;
  logic [OCC_W-1:0] occ_count;

  assign occ_in_fire  = In_valid & In_ready;
  assign occ_out_fire = Out_valid & Out_ready;

  // Word count tracks boundary transfers: +1 on accept, -1 on delivery, hold on both or neither.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      occ_count <= '0;
    end else begin
      case ({occ_in_fire, occ_out_fire})
        2'b10:   occ_count <= occ_count + OCC_W'(1);
        2'b01:   occ_count <= occ_count - OCC_W'(1);
        default: occ_count <= occ_count;
      endcase
    end
  end

  assign Occupancy = occ_count;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed and random bench for elastic_pipeline (WORD_LENGTH=8, STAGES=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Occupancy is checked only when ELASTIC_PIPELINE_OCCUPANCY_EN is defined.
module tb_elastic_pipeline;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int NW = 10000;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] In_data;
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] Out_data;
  logic         Out_valid;
  logic         Out_ready;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  logic [$clog2(2*S+1)-1:0] Occupancy;
`endif

  int checks = 0;
  int errors = 0;

  elastic_pipeline #(.WORD_LENGTH(W), .STAGES(S)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In_data  (In_data),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Out_data (Out_data),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    ,
    .Occupancy(Occupancy)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    chk(tag, 32'(Occupancy), 32'(exp));
`endif
  endtask

  // Stall the consumer and keep offering base, base+1, ... for 6 cycles; returns words accepted.
  task automatic fill(input logic [W-1:0] base, output int acc);
    logic fire;
    acc       = 0;
    Out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      In_valid = 1'b1;
      In_data  = base + W'(acc);
      fire     = In_ready;
      tick();
      if (fire) acc++;
    end
  endtask

  initial begin
    int            acc;
    int            sent;
    int            got;
    int            cyc;
    int            waited;
    logic [W-1:0]  q[$];
    logic [W-1:0]  exp_w;
    logic [W-1:0]  prev_data;
    logic          prev_stall;
    logic          pending;
    logic          in_f;
    logic          out_f;

    Reset     = 1'b0;
    In_data   = '0;
    In_valid  = 1'b0;
    Out_ready = 1'b0;

    // ---- 1: reset state ----
    tick();
    chk("rst_in_ready_during", 32'(In_ready), 32'd1);
    tick();
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_out_data", 32'(Out_data), 32'd0);
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    chk_occ("rst_occ", 0);
    Reset = 1'b1;

    // ---- 2: streaming; word offered in cycle i is on Out in cycle i+S ----
    Out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      In_valid = 1'b1;
      In_data  = W'(i + 1);
      chk("stream_in_ready", 32'(In_ready), 32'd1);
      tick();
      if (i == 0) begin
        chk("stream_lat_early", 32'(Out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(Out_valid), 32'd1);
        chk("stream_data", 32'(Out_data), 32'(i));
      end
    end
    In_valid = 1'b0;
    tick();
    chk("stream_last_valid", 32'(Out_valid), 32'd1);
    chk("stream_last_data", 32'(Out_data), 32'h10);
    tick();
    chk("stream_empty", 32'(Out_valid), 32'd0);
    chk("stream_hold_data", 32'(Out_data), 32'h10);

    // ---- 3: stall to full, then drain ----
    fill(8'hA0, acc);
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_in_ready", 32'(In_ready), 32'd0);
    chk("full_out_valid", 32'(Out_valid), 32'd1);
    chk("full_out_data", 32'(Out_data), 32'hA0);
    chk_occ("full_occ", 4);
    tick();
    chk("full_stable_data", 32'(Out_data), 32'hA0);
    chk("full_no_accept", 32'(In_ready), 32'd0);
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_valid", 32'(Out_valid), 32'd1);
      chk("drain_data", 32'(Out_data), 32'(8'hA0 + j));
      tick();
    end
    chk("drain_empty", 32'(Out_valid), 32'd0);
    chk_occ("drain_occ", 0);

    // ---- 5: full, one-cycle pop while a push is pending ----
    fill(8'hB0, acc);
    chk("pp_accepted", 32'(acc), 32'd4);
    In_valid  = 1'b1;
    In_data   = 8'hB4;
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
    chk("pp_one_out", 32'(Out_data), 32'hB1);
    chk_occ("pp_occ3", 3);
    // Freed space ripples back to slice 0 one edge later.
    tick();
    chk("pp_in_ready_back", 32'(In_ready), 32'd1);
    tick();
    In_valid = 1'b0;
    chk("pp_refull", 32'(In_ready), 32'd0);
    chk_occ("pp_occ4", 4);
    Out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      chk("pp_drain_valid", 32'(Out_valid), 32'd1);
      chk("pp_drain_data", 32'(Out_data), 32'(8'hB0 + j));
      tick();
    end
    chk("pp_drain_empty", 32'(Out_valid), 32'd0);

    // ---- 4: random valid/ready with scoreboard ----
    sent       = 0;
    got        = 0;
    cyc        = 0;
    pending    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    In_valid   = 1'b0;
    while (got < NW && cyc < 60000) begin
      if (!pending) begin
        if (sent < NW && $urandom_range(0, 1) == 1) begin
          In_valid = 1'b1;
          In_data  = W'($urandom);
        end else begin
          In_valid = 1'b0;
        end
      end
      Out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        chk("rand_stall_valid", 32'(Out_valid), 32'd1);
        chk("rand_stall_data", 32'(Out_data), 32'(prev_data));
      end
      in_f  = In_valid && In_ready;
      out_f = Out_valid && Out_ready;
      if (out_f) begin
        chk("rand_sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_w = q.pop_front();
          chk("rand_data", 32'(Out_data), 32'(exp_w));
        end
        got++;
      end
      if (in_f) begin
        q.push_back(In_data);
        sent++;
      end
      prev_stall = Out_valid && !Out_ready;
      prev_data  = Out_data;
      pending    = In_valid && !In_ready;
      tick();
      cyc++;
      chk_occ("rand_occ", q.size());
    end
    chk("rand_words_out", 32'(got), 32'(NW));
    chk("rand_sb_drained", 32'(q.size()), 32'd0);
    In_valid  = 1'b0;
    Out_ready = 1'b0;
    tick();
    tick();

    // ---- 6: reset mid-stream with 3 words held ----
    chk("mid_pre_empty", 32'(Out_valid), 32'd0);
    for (int j = 0; j < 3; j++) begin
      In_valid = 1'b1;
      In_data  = W'(8'hC0 + j);
      tick();
    end
    chk_occ("mid_occ3", 3);
    chk("mid_held_valid", 32'(Out_valid), 32'd1);
    Reset    = 1'b0;
    In_data  = 8'hEE;
    tick();
    chk("mid_rst_out_valid", 32'(Out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(Out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(In_ready), 32'd1);
    chk_occ("mid_rst_occ", 0);
    Reset     = 1'b1;
    In_valid  = 1'b1;
    In_data   = 8'h55;
    Out_ready = 1'b1;
    tick();
    In_valid = 1'b0;
    waited   = 0;
    while (!Out_valid && waited < 10) begin
      tick();
      waited++;
    end
    chk("post_rst_valid", 32'(Out_valid), 32'd1);
    chk("post_rst_first", 32'(Out_data), 32'h55);
    tick();
    chk("post_rst_only_one", 32'(Out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
